// File: rtl/slave_proto_pkg.sv
// Shared constants for the slave request/response packet protocol:
// widths, opcode/status codes, field positions, responder FSM states.
package slave_proto_pkg;

  localparam int DATA_LINE_WIDTH    = 64;
  localparam int CONTROL_LINE_WIDTH = 6;
  localparam int PKT_WIDTH          = 70;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [1:0] ST_READ_OK  = 2'b00;
  localparam logic [1:0] ST_WRITE_OK = 2'b01;
  localparam logic [1:0] ST_NOP_ACK  = 2'b10;
  localparam logic [1:0] ST_ERROR    = 2'b11;

  localparam int OP_HI    = 69;
  localparam int OP_LO    = 68;
  localparam int TAG_HI   = 67;
  localparam int TAG_LO   = 64;
  localparam int WDATA_HI = 63;
  localparam int WDATA_LO = 32;
  localparam int ADDR_HI  = 31;
  localparam int ADDR_LO  = 0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POP     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_PUSH    = 3'd4;

  function automatic logic [PKT_WIDTH-1:0] make_resp(
    input logic [1:0]  status,
    input logic [3:0]  tag,
    input logic [31:0] rdata,
    input logic [31:0] addr
  );
    return {status, tag, rdata, addr};
  endfunction

endpackage

// File: rtl/slave_word_mem.sv
// Local word memory: MEM_DEPTH x 32, synchronous write and clear,
// combinational read. Ports: clk, rst, we, addr, wdata, rdata.
module slave_word_mem #(
  parameter int MEM_DEPTH      = 32,
  parameter int LOG2_MEM_DEPTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [LOG2_MEM_DEPTH-1:0] addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata
);

  logic [31:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/slave_responder.sv
// Slave endpoint: pops requests, executes them on local memory, pushes
// one response each. Ports: clk, rst, request FIFO pop side, response
// FIFO push side, o_busy, o_err_count (saturating error counter).
module slave_responder #(
  parameter int DATA_LINE_WIDTH    = 64,
  parameter int CONTROL_LINE_WIDTH = 6,
  parameter int MEM_DEPTH          = 32,
  parameter int LOG2_MEM_DEPTH     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sc_rreq_fifo_empty,
  input  logic [CONTROL_LINE_WIDTH+DATA_LINE_WIDTH-1:0] i_sc_rreq_outbits,
  output logic o_sc_rreq_ren,
  input  logic i_sc_sresp_fifo_full,
  output logic o_sc_sresp_wen,
  output logic [CONTROL_LINE_WIDTH+DATA_LINE_WIDTH-1:0] o_sc_sresp_inbits,
  output logic o_busy,
  output logic [7:0] o_err_count
);

  import slave_proto_pkg::*;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [PKT_WIDTH-1:0] req_q;
  logic [PKT_WIDTH-1:0] resp_q;
  logic [7:0]           err_q;

  logic [1:0]  op;
  logic [3:0]  tag;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic        addr_ok;
  logic [31:0] mem_rdata;
  logic [1:0]  status;
  logic        mem_we;
  logic        push;

  assign op    = req_q[OP_HI:OP_LO];
  assign tag   = req_q[TAG_HI:TAG_LO];
  assign wdata = req_q[WDATA_HI:WDATA_LO];
  assign addr  = req_q[ADDR_HI:ADDR_LO];

  // Full 32-bit compare rejects both stray high bits and
  // in-range-width indices beyond the depth.
  assign addr_ok = addr < 32'(MEM_DEPTH);

  always_comb begin
    status = ST_ERROR;
    case (op)
      OP_NOP:   status = ST_NOP_ACK;
      OP_READ:  if (addr_ok) status = ST_READ_OK;
      OP_WRITE: if (addr_ok) status = ST_WRITE_OK;
      OP_ILL:   status = ST_ERROR;
    endcase
  end

  assign mem_we = (state == S_EXEC) && (status == ST_WRITE_OK);

  slave_word_mem #(
    .MEM_DEPTH      (MEM_DEPTH),
    .LOG2_MEM_DEPTH (LOG2_MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .addr  (addr[LOG2_MEM_DEPTH-1:0]),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  // Strobes are masked by rst so nothing fires while reset is held,
  // even if the FSM sits in POP/PUSH when reset arrives.
  assign o_sc_rreq_ren = (state == S_POP) && !rst;
  assign push = (state == S_PUSH) && !i_sc_sresp_fifo_full && !rst;
  assign o_sc_sresp_wen = push;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!i_sc_rreq_fifo_empty) state_nxt = S_POP;
      S_POP:     state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_PUSH;
      S_PUSH:    if (!i_sc_sresp_fifo_full) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      req_q  <= '0;
      resp_q <= '0;
      err_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CAPTURE) begin
        req_q <= i_sc_rreq_outbits;
      end
      if (state == S_EXEC) begin
        resp_q <= make_resp(status, tag,
                            (status == ST_READ_OK) ? mem_rdata : '0,
                            addr);
      end
      if (push && resp_q[OP_HI:OP_LO] == ST_ERROR && err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign o_sc_sresp_inbits = resp_q;
  assign o_busy            = (state != S_IDLE);
  assign o_err_count       = err_q;

endmodule
